// File: rtl/rib_wr_responder_pkg.sv
// rib_wr_responder_pkg: shared RIB write-path widths and constants
package rib_wr_responder_pkg;
  localparam int RIB_AW = 32;
  localparam int RIB_DW = 32;
  localparam int RIB_DEPTH = 4;
  localparam int RIB_PTR_W = 2;
  localparam logic [RIB_DW-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/rib_wr_responder_sb_fifo.sv
// rib_wr_responder_sb_fifo: in-order store buffer with exposed entries for forwarding
module rib_wr_responder_sb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int PTR_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr,
  output logic [DEPTH-1:0][DW-1:0]   ent_data,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [PTR_W-1:0]           wr_ptr,
  output logic [PTR_W-1:0]           rd_ptr,
  output logic [PTR_W:0]             count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ent_valid <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      for (int i = 0; i < DEPTH; i++)
        ent_valid[i] <= (push && wr_ptr == PTR_W'(i)) ? 1'b1 :
                        (pop && rd_ptr == PTR_W'(i)) ? 1'b0 : ent_valid[i];
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= push_addr;
      ent_data[wr_ptr] <= push_data;
    end
  end
endmodule

// File: rtl/rib_wr_responder.sv
// rib_wr_responder: buffers core word writes, drains them to RAM, forwards to loads
module rib_wr_responder
  import rib_wr_responder_pkg::*;
#(
  parameter int DEPTH = RIB_DEPTH,
  parameter int AW = RIB_AW,
  parameter int DW = RIB_DW,
  parameter int PTR_W = RIB_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_rib_req_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [DW-1:0]    wr_data_i,
  output logic             rib_hold_flag_o,
  output logic             ram_wr_en_o,
  output logic [AW-1:0]    ram_wr_addr_o,
  output logic [DW-1:0]    ram_wr_data_o,
  input  logic             ram_ready_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic             rd_hit_o,
  output logic [DW-1:0]    rd_data_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [DEPTH-1:0]         ent_valid;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr, idx;
  logic                     push, pop, unused_rd_lsb;
  assign unused_rd_lsb = ^{rd_addr_i[1:0], wr_ptr};
  assign rib_hold_flag_o = count_o == (PTR_W+1)'(DEPTH);
  assign empty_o = count_o == '0;
  assign push = wr_rib_req_i & wr_en_i & ~rib_hold_flag_o;
  assign ram_wr_en_o = ~empty_o;
  assign pop = ram_wr_en_o & ram_ready_i;
  assign ram_wr_addr_o = empty_o ? '0 : ent_addr[rd_ptr];
  assign ram_wr_data_o = empty_o ? ZERO_WORD[DW-1:0] : ent_data[rd_ptr];
  rib_wr_responder_sb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PTR_W(PTR_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .push_addr(wr_addr_i),
    .push_data(wr_data_i),
    .ent_addr(ent_addr),
    .ent_data(ent_data),
    .ent_valid(ent_valid),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count(count_o)
  );
  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    rd_hit_o = 1'b0;
    rd_data_o = '0;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (ent_valid[idx] && ent_addr[idx][AW-1:2] == rd_addr_i[AW-1:2]) begin
        rd_hit_o = 1'b1;
        rd_data_o = ent_data[idx];
      end
    end
  end
endmodule
